cnn_ctrl: RTL and testbench

//  Frame-timing controller (FSM) for the CNN accelerator datapath. On a start request it

---
 rtl/cnn_ctrl_if.sv | 41 ++++
 rtl/cnn_ctrl.sv | 170 +++++++++++++++++
 tb/tb_cnn_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/cnn_ctrl_if.sv
// -----------------------------------------------------------------------------
// cnn_ctrl_if
// Bundles the frame-timing controller's configuration/start inputs and its
// timing outputs into one interface.
//   master : drives q_* (configuration + start), observes o_* (timing outputs)
//   slave  : the controller itself; reads q_*, drives o_*
// -----------------------------------------------------------------------------
interface cnn_ctrl_if #(
    parameter int W_SIZE       = 12,
    parameter int W_FRAME_SIZE = 25,
    parameter int W_DELAY      = 12
);
    logic [W_SIZE-1:0]       q_width;
    logic [W_SIZE-1:0]       q_height;
    logic [W_DELAY-1:0]      q_vsync_delay;
    logic [W_DELAY-1:0]      q_hsync_delay;
    logic [W_FRAME_SIZE-1:0] q_frame_size;
    logic                    q_start;

    logic                    o_ctrl_vsync_run;
    logic [W_DELAY-1:0]      o_ctrl_vsync_cnt;
    logic                    o_ctrl_hsync_run;
    logic [W_DELAY-1:0]      o_ctrl_hsync_cnt;
    logic                    o_ctrl_data_run;
    logic [W_SIZE-1:0]       o_row;
    logic [W_SIZE-1:0]       o_col;
    logic [W_FRAME_SIZE-1:0] o_data_count;
    logic                    o_end_frame;

    modport master (
        output q_width, q_height, q_vsync_delay, q_hsync_delay, q_frame_size, q_start,
        input  o_ctrl_vsync_run, o_ctrl_vsync_cnt, o_ctrl_hsync_run, o_ctrl_hsync_cnt,
               o_ctrl_data_run, o_row, o_col, o_data_count, o_end_frame
    );

    modport slave (
        input  q_width, q_height, q_vsync_delay, q_hsync_delay, q_frame_size, q_start,
        output o_ctrl_vsync_run, o_ctrl_vsync_cnt, o_ctrl_hsync_run, o_ctrl_hsync_cnt,
               o_ctrl_data_run, o_row, o_col, o_data_count, o_end_frame
    );
endinterface

// File: rtl/cnn_ctrl.sv
// -----------------------------------------------------------------------------
// cnn_ctrl
// Frame-timing controller for the CNN accelerator datapath. A rising edge on
// q_start (accepted only when idle) runs one frame: a vertical-sync delay, then
// for every line a horizontal-sync delay followed by q_width data cycles.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rstn : asynchronous reset, active HIGH despite the name (1 = in reset)
//   bus  : cnn_ctrl_if.slave
//          q_width/q_height      frame geometry (>=1)
//          q_vsync_delay         cycles in VSYNC (0 behaves as 1)
//          q_hsync_delay         cycles in HSYNC before each line (0 behaves as 1)
//          q_frame_size          data cycles per frame; may end the frame early
//          q_start               start request level, rising edge used
//          o_ctrl_*_run/_cnt     phase flags and cycle index within the phase
//          o_row/o_col           current line / pixel index
//          o_data_count          linear pixel index within the frame
//          o_end_frame           one-cycle pulse on the last data cycle
// -----------------------------------------------------------------------------
module cnn_ctrl #(
    parameter int W_SIZE       = 12,
    parameter int W_FRAME_SIZE = 25,
    parameter int W_DELAY      = 12
) (
    input logic       clk,
    input logic       rstn,
    cnn_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_VSYNC = 2'd1,
        S_HSYNC = 2'd2,
        S_DATA  = 2'd3
    } state_t;

    state_t                  state_r;
    logic                    start_d_r;
    logic                    vsync_run_r;
    logic [W_DELAY-1:0]      vsync_cnt_r;
    logic                    hsync_run_r;
    logic [W_DELAY-1:0]      hsync_cnt_r;
    logic                    data_run_r;
    logic [W_SIZE-1:0]       row_r;
    logic [W_SIZE-1:0]       col_r;
    logic [W_FRAME_SIZE-1:0] data_count_r;

    logic                    start_pulse_s;
    logic [W_DELAY-1:0]      vsync_len_s;
    logic [W_DELAY-1:0]      hsync_len_s;
    logic                    vsync_last_s;
    logic                    hsync_last_s;
    logic                    line_last_s;
    logic                    frame_last_s;

    // Phase-end decodes; a zero delay still spends one cycle in its phase.
    always_comb begin
        start_pulse_s = bus.q_start & ~start_d_r;
        vsync_len_s   = (bus.q_vsync_delay == W_DELAY'(0)) ? W_DELAY'(1) : bus.q_vsync_delay;
        hsync_len_s   = (bus.q_hsync_delay == W_DELAY'(0)) ? W_DELAY'(1) : bus.q_hsync_delay;
        vsync_last_s  = (vsync_cnt_r == (vsync_len_s - W_DELAY'(1)));
        hsync_last_s  = (hsync_cnt_r == (hsync_len_s - W_DELAY'(1)));
        line_last_s   = (col_r == (bus.q_width - W_SIZE'(1)));
        // Either the geometric last pixel or an earlier frame-size limit ends the frame.
        frame_last_s  = (state_r == S_DATA) &&
                        (((row_r == (bus.q_height - W_SIZE'(1))) && line_last_s) ||
                         (data_count_r == (bus.q_frame_size - W_FRAME_SIZE'(1))));
    end

    // Start-edge register: tracks the previous q_start level.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            start_d_r <= 1'b0;
        end else begin
            start_d_r <= bus.q_start;
        end
    end

    // Frame sequencer: state, phase flags, delay counters and pixel indices.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_r      <= S_IDLE;
            vsync_run_r  <= 1'b0;
            vsync_cnt_r  <= W_DELAY'(0);
            hsync_run_r  <= 1'b0;
            hsync_cnt_r  <= W_DELAY'(0);
            data_run_r   <= 1'b0;
            row_r        <= W_SIZE'(0);
            col_r        <= W_SIZE'(0);
            data_count_r <= W_FRAME_SIZE'(0);
        end else begin
            case (state_r)
                S_IDLE: begin
                    vsync_cnt_r  <= W_DELAY'(0);
                    hsync_run_r  <= 1'b0;
                    hsync_cnt_r  <= W_DELAY'(0);
                    data_run_r   <= 1'b0;
                    row_r        <= W_SIZE'(0);
                    col_r        <= W_SIZE'(0);
                    data_count_r <= W_FRAME_SIZE'(0);
                    if (start_pulse_s) begin
                        state_r     <= S_VSYNC;
                        vsync_run_r <= 1'b1;
                    end else begin
                        vsync_run_r <= 1'b0;
                    end
                end
                S_VSYNC: begin
                    if (vsync_last_s) begin
                        state_r     <= S_HSYNC;
                        vsync_run_r <= 1'b0;
                        vsync_cnt_r <= W_DELAY'(0);
                        hsync_run_r <= 1'b1;
                    end else begin
                        vsync_cnt_r <= vsync_cnt_r + W_DELAY'(1);
                    end
                end
                S_HSYNC: begin
                    if (hsync_last_s) begin
                        state_r     <= S_DATA;
                        hsync_run_r <= 1'b0;
                        hsync_cnt_r <= W_DELAY'(0);
                        data_run_r  <= 1'b1;
                    end else begin
                        hsync_cnt_r <= hsync_cnt_r + W_DELAY'(1);
                    end
                end
                S_DATA: begin
                    if (frame_last_s) begin
                        state_r      <= S_IDLE;
                        data_run_r   <= 1'b0;
                        row_r        <= W_SIZE'(0);
                        col_r        <= W_SIZE'(0);
                        data_count_r <= W_FRAME_SIZE'(0);
                    end else if (line_last_s) begin
                        state_r      <= S_HSYNC;
                        data_run_r   <= 1'b0;
                        hsync_run_r  <= 1'b1;
                        row_r        <= row_r + W_SIZE'(1);
                        col_r        <= W_SIZE'(0);
                        data_count_r <= data_count_r + W_FRAME_SIZE'(1);
                    end else begin
                        col_r        <= col_r + W_SIZE'(1);
                        data_count_r <= data_count_r + W_FRAME_SIZE'(1);
                    end
                end
                default: begin
                    state_r      <= S_IDLE;
                    vsync_run_r  <= 1'b0;
                    vsync_cnt_r  <= W_DELAY'(0);
                    hsync_run_r  <= 1'b0;
                    hsync_cnt_r  <= W_DELAY'(0);
                    data_run_r   <= 1'b0;
                    row_r        <= W_SIZE'(0);
                    col_r        <= W_SIZE'(0);
                    data_count_r <= W_FRAME_SIZE'(0);
                end
            endcase
        end
    end

    assign bus.o_ctrl_vsync_run = vsync_run_r;
    assign bus.o_ctrl_vsync_cnt = vsync_cnt_r;
    assign bus.o_ctrl_hsync_run = hsync_run_r;
    assign bus.o_ctrl_hsync_cnt = hsync_cnt_r;
    assign bus.o_ctrl_data_run  = data_run_r;
    assign bus.o_row            = row_r;
    assign bus.o_col            = col_r;
    assign bus.o_data_count     = data_count_r;
    assign bus.o_end_frame      = frame_last_s;
endmodule

// File: tb/tb_cnn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cnn_ctrl
// Self-checking bench for cnn_ctrl. A reference model expands each accepted
// start into the full list of per-cycle output tuples of the frame (VSYNC
// cycles, then per line HSYNC cycles and pixels), and every clock the DUT
// outputs are compared against the next tuple (all zero when idle).
// -----------------------------------------------------------------------------
module tb_cnn_ctrl;
    localparam int W_SIZE       = 12;
    localparam int W_FRAME_SIZE = 25;
    localparam int W_DELAY      = 12;
    localparam int RUN_BOUND    = 90000;

    logic clk;
    logic rstn;

    cnn_ctrl_if #(.W_SIZE(W_SIZE), .W_FRAME_SIZE(W_FRAME_SIZE), .W_DELAY(W_DELAY)) bus_if ();

    cnn_ctrl #(.W_SIZE(W_SIZE), .W_FRAME_SIZE(W_FRAME_SIZE), .W_DELAY(W_DELAY)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks_cnt;
    int          failures_cnt;
    logic [76:0] exp_q[$];
    logic        prev_start;
    int          ef_count;
    int          ef_dc;

    // Compare one observed value against its expectation.
    task automatic check_val(input string tag, input logic [76:0] obs, input logic [76:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            failures_cnt++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [76:0] mk(input int vr, input int vc, input int hr, input int hc,
                                       input int dr, input int row, input int col,
                                       input int dc, input int ef);
        return {1'(vr), 12'(vc), 1'(hr), 12'(hc), 1'(dr), 12'(row), 12'(col), 25'(dc), 1'(ef)};
    endfunction

    function automatic logic [76:0] obs_vec();
        return {bus_if.o_ctrl_vsync_run, bus_if.o_ctrl_vsync_cnt, bus_if.o_ctrl_hsync_run,
                bus_if.o_ctrl_hsync_cnt, bus_if.o_ctrl_data_run, bus_if.o_row, bus_if.o_col,
                bus_if.o_data_count, bus_if.o_end_frame};
    endfunction

    // Expand one frame from the current configuration into expected tuples.
    task automatic build_frame();
        int  w, h, d, hs, fs, dc;
        bit  done, last;
        w  = int'(bus_if.q_width);
        h  = int'(bus_if.q_height);
        d  = (bus_if.q_vsync_delay == 0) ? 1 : int'(bus_if.q_vsync_delay);
        hs = (bus_if.q_hsync_delay == 0) ? 1 : int'(bus_if.q_hsync_delay);
        fs = int'(bus_if.q_frame_size);
        for (int i = 0; i < d; i++) exp_q.push_back(mk(1, i, 0, 0, 0, 0, 0, 0, 0));
        done = 1'b0;
        for (int r = 0; r < h && !done; r++) begin
            for (int i = 0; i < hs; i++) exp_q.push_back(mk(0, 0, 1, i, 0, r, 0, r * w, 0));
            for (int c = 0; c < w && !done; c++) begin
                dc   = r * w + c;
                last = ((r == h - 1) && (c == w - 1)) || (dc == fs - 1);
                exp_q.push_back(mk(0, 0, 0, 0, 1, r, c, dc, int'(last)));
                done = last;
            end
        end
        exp_q.push_back('0);
    endtask

    // Advance one clock and check the DUT against the model.
    task automatic tick();
        logic [76:0] e;
        if (!rstn && bus_if.q_start && !prev_start && exp_q.size() == 0) build_frame();
        prev_start = rstn ? 1'b0 : bus_if.q_start;
        @(posedge clk);
        #1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 77'd0;
        check_val("cycle", obs_vec(), e);
        if (bus_if.o_end_frame) begin
            ef_count++;
            ef_dc = int'(bus_if.o_data_count);
        end
    endtask

    task automatic set_cfg(input int w, input int h, input int d, input int hs, input int fs);
        bus_if.q_width       = W_SIZE'(w);
        bus_if.q_height      = W_SIZE'(h);
        bus_if.q_vsync_delay = W_DELAY'(d);
        bus_if.q_hsync_delay = W_DELAY'(hs);
        bus_if.q_frame_size  = W_FRAME_SIZE'(fs);
    endtask

    // Create a fresh rising edge on q_start and leave it high.
    task automatic start_frame();
        bus_if.q_start = 1'b0;
        tick();
        bus_if.q_start = 1'b1;
        tick();
    endtask

    // Run until the model has no pending tuples; optionally jitter q_start.
    task automatic run_done(input bit jitter);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < RUN_BOUND) begin
            if (jitter) bus_if.q_start = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        if (exp_q.size() > 0) begin
            check_val("run_timeout", 77'd1, 77'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        int busy, w, h;
        checks_cnt   = 0;
        failures_cnt = 0;
        prev_start   = 1'b0;
        ef_count     = 0;
        ef_dc        = 0;

        // Reset held with random inputs, then released with no start.
        rstn = 1'b1;
        set_cfg($urandom_range(1, 50), $urandom_range(1, 50), $urandom_range(0, 50),
                $urandom_range(0, 50), $urandom_range(1, 500));
        bus_if.q_start = 1'($urandom_range(0, 1));
        for (int i = 0; i < 3; i++) tick();
        bus_if.q_start = 1'b0;
        rstn = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // Small exact frame with cycle-count check.
        set_cfg(4, 2, 3, 2, 8);
        start_frame();
        busy = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus_if.o_ctrl_vsync_run | bus_if.o_ctrl_hsync_run | bus_if.o_ctrl_data_run) busy++;
            else break;
        end
        check_val("latency", 77'(busy + 1), 77'd16);
        run_done(1'b0);

        // Frame-size limit ends the frame early.
        ef_count = 0;
        set_cfg(4, 2, 3, 2, 5);
        start_frame();
        run_done(1'b0);
        check_val("early_ef_count", 77'(ef_count), 77'd1);
        check_val("early_ef_dc", 77'(ef_dc), 77'd4);

        // Start edges mid-frame ignored; held-high start after the frame starts nothing.
        set_cfg(3, 2, 2, 1, 6);
        start_frame();
        for (int i = 0; i < 3; i++) tick();
        bus_if.q_start = 1'b0;
        tick();
        bus_if.q_start = 1'b1;
        run_done(1'b0);
        for (int i = 0; i < 4; i++) tick();
        start_frame();
        run_done(1'b0);

        // Asynchronous reset during DATA, then a full frame.
        set_cfg(5, 3, 2, 2, 15);
        start_frame();
        for (int i = 0; i < 40 && !bus_if.o_ctrl_data_run; i++) tick();
        tick();
        check_val("in_data", 77'(bus_if.o_ctrl_data_run), 77'd1);
        #2;
        rstn = 1'b1;
        #1;
        check_val("async_rst", obs_vec(), 77'd0);
        exp_q.delete();
        bus_if.q_start = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        start_frame();
        run_done(1'b0);

        // Randomized frames with start jitter during the frame.
        for (int k = 0; k < 20; k++) begin
            w = $urandom_range(1, 6);
            h = $urandom_range(1, 4);
            set_cfg(w, h, $urandom_range(0, 4), $urandom_range(0, 3),
                    ($urandom_range(0, 1) == 1) ? w * h : $urandom_range(1, w * h + 3));
            start_frame();
            run_done(1'b1);
            bus_if.q_start = 1'b0;
            tick();
        end

        // Large frame: 256x256, end_frame exactly once at the last pixel.
        ef_count = 0;
        set_cfg(256, 256, 100, 1, 65536);
        start_frame();
        run_done(1'b0);
        check_val("big_ef_count", 77'(ef_count), 77'd1);
        check_val("big_ef_dc", 77'(ef_dc), 77'd65535);
        for (int i = 0; i < 3; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end
endmodule
